jtag_gpio_tap: RTL and testbench
================================

Name: jtag_gpio_tap

Overview:
- IEEE 1149.1 TAP responder for the jtag_gpios design: the device-side end of the JTAG host sequence driven on tck/tms/tdi.
- Contains the 16-state TAP controller, a 4-bit IR, and three data registers: IDCODE, BYPASS and a GPIO data register.
- The GPIO register samples button/GPIO inputs in Capture-DR and drives LED/GPIO outputs from Update-DR.
- Sits in top between the JTAG pins and the LED/button logic; the whole block runs in the tck domain.

Parameters:
- IR_LENGTH, 4, instruction register width (fixed at 4; the opcodes below assume it)
- IDCODE_VAL, 32'h149511C3, value captured into IDCODE DR; bit0 must be 1
- NR_GPIO, 4, width of the GPIO data register
- IR_CAPTURE, 4'b0101, value loaded into the IR shift register in Capture-IR; bits[1:0] must be 2'b01

Ports:
- tck  input  1  JTAG test clock
- trst_  input  1  reset, asynchronous, active-high
- tms  input  1  test mode select, sampled on posedge tck
- tdi  input  1  test data in, sampled on posedge tck
- tdo  output  1  test data out, changes on negedge tck
- tdo_oe  output  1  high while shifting (Shift-IR/Shift-DR), registered on negedge tck
- gpio_in  input  NR_GPIO  sampled in Capture-DR when IR=GPIO
- gpio_out  output  NR_GPIO  driven from GPIO update register
- gpio_upd  output  1  one-tck pulse in Update-DR when IR=GPIO
- tap_state  output  4  current TAP state encoding, for debug

Behaviour:
- Reset (trst_=1, asynchronous):
  - state=TEST_LOGIC_RESET, IR=IDCODE (4'h1), IR shift register=0, DR shift register=0.
  - tdo=0, tdo_oe=0, gpio_out=0, gpio_upd=0.
- FSM:
  - Standard 1149.1 16-state graph, advanced on posedge tck by tms.
  - TLR: tms0→RTI. RTI: tms1→SELDR. SELDR: tms0→CAPDR, tms1→SELIR. SELIR: tms0→CAPIR, tms1→TLR.
  - CAPx: 0→SHIFTx, 1→EXIT1x. SHIFTx: 1→EXIT1x. EXIT1x: 0→PAUSEx, 1→UPDx.
  - PAUSEx: 1→EXIT2x. EXIT2x: 0→SHIFTx, 1→UPDx. UPDx: 0→RTI, 1→SELDR.
  - Every unlisted tms value stays in the current state.
  - Five consecutive tms=1 posedges reach TLR from any state.
- TLR is synchronous test-logic reset: IR←IDCODE each cycle spent in TLR. gpio_out is NOT cleared by TLR; only trst_ clears it.
- Instructions:
  - 4'h1 IDCODE.
  - 4'hA GPIO.
  - 4'hF BYPASS.
  - All other opcodes select BYPASS.
- All actions below occur on posedge tck while in the named state.
- IR path:
  - CAPIR: IR shift register←IR_CAPTURE.
  - SHIFTIR: shift right; tdi enters the MSB.
  - UPDIR: IR←IR shift register.
- DR path, register selected by the current IR:
  - CAPDR:
    - IDCODE: load IDCODE_VAL.
    - BYPASS: load 1 bit of 0.
    - GPIO: load gpio_in.
  - SHIFTDR: shift right; tdi enters the MSB of the selected register length (32 / 1 / NR_GPIO).
  - UPDDR with IR=GPIO: gpio_out←shift register; gpio_upd=1 for exactly that one cycle.
  - UPDDR with other IRs: no effect.
- TDO:
  - On negedge tck, tdo←LSB of the active shift register (IR path in SHIFTIR, DR path in SHIFTDR).
  - tdo_oe←(state==SHIFTIR || state==SHIFTDR).
  - Outside the shift states, tdo holds 0.
  - The first bit out is therefore the captured LSB; latency through BYPASS is exactly 1 shift.
- PAUSE/EXIT2 preserve shift-register contents; resuming SHIFT continues the same scan.
- IR changes only in UPDIR or TLR. A DR scan in progress when IR would change cannot occur, because the IR and DR paths are exclusive.
- trst_ asserted mid-shift: immediate TLR, tdo_oe=0 and tdo=0 without waiting for tck, partial scan discarded, gpio_out=0.

Decomposition:
- Package jtag_tap_pkg:
  - TAP state enum (4-bit, 16 codes: TLR=0 … UPDIR=15).
  - Opcode constants IR_IDCODE, IR_GPIO, IR_BYPASS.
  - IR_LENGTH.
  - Consistent with the existing jtag_tap_defines.
- Sub-module jtag_tap_fsm:
  - Ports tck, trst_, tms → state.
  - Decoded one-hot strobes: capture_ir/dr, shift_ir/dr, update_ir/dr, test_logic_reset.
- Top block holds the IR, the DR shift registers, the GPIO update register and the negedge TDO stage.

Test Plan:
- IDCODE readout: trst_ pulse, tms=0 to RTI, then 1,0,0 to SHIFTDR; shift 32 bits of tdi=0 with tms=1 on the last → tdo (sampled on posedge) = 32'h149511C3 LSB-first; tdo_oe high exactly those 32 cycles.
- IR capture: set IR shifting 4'b1111 → tdo bits 1,0,1,0; after UPDIR, tap_state passes UPDIR then RTI; IR=4'hF.
- BYPASS: IR=4'hF, shift 8'hC1 then 1 extra bit of 0 → tdo sequence 0,1,0,0,0,0,0,1,1 (one-cycle delay).
- GPIO: IR=4'hA, gpio_in=4'b1001, shift 4'b0110 → tdo 1,0,0,1; at UPDDR gpio_out=4'b0110 and gpio_upd high for exactly 1 tck.
- Sync reset: from SHIFTDR apply tms=1 for 5 tcks → TLR, IR=IDCODE, gpio_out unchanged (4'b0110), tdo_oe=0; unused opcode 4'h3 then behaves as BYPASS.
- Async reset: assert trst_ mid-GPIO shift between tck edges → tap_state=TLR, tdo=0, tdo_oe=0, gpio_out=0 immediately; a subsequent IDCODE scan is correct.

Source files
------------

// File: rtl/jtag_tap_pkg.sv
// Shared definitions for the jtag_gpios TAP: state encoding, IR width,
// opcodes and the instruction-to-data-register decode.
package jtag_tap_pkg;

  localparam int IR_LENGTH = 4;

  localparam logic [IR_LENGTH-1:0] IR_IDCODE = 4'h1;
  localparam logic [IR_LENGTH-1:0] IR_GPIO   = 4'hA;
  localparam logic [IR_LENGTH-1:0] IR_BYPASS = 4'hF;

  typedef enum logic [3:0] {
    TLR     = 4'd0,
    RTI     = 4'd1,
    SELDR   = 4'd2,
    CAPDR   = 4'd3,
    SHIFTDR = 4'd4,
    EXIT1DR = 4'd5,
    PAUSEDR = 4'd6,
    EXIT2DR = 4'd7,
    UPDDR   = 4'd8,
    SELIR   = 4'd9,
    CAPIR   = 4'd10,
    SHIFTIR = 4'd11,
    EXIT1IR = 4'd12,
    PAUSEIR = 4'd13,
    EXIT2IR = 4'd14,
    UPDIR   = 4'd15
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_GPIO
  } dr_sel_e;

  // Unknown opcodes fall back to BYPASS so a scan chain never breaks.
  function automatic dr_sel_e decode_ir(input logic [IR_LENGTH-1:0] ir);
    case (ir)
      IR_IDCODE: return DR_IDCODE;
      IR_GPIO:   return DR_GPIO;
      default:   return DR_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller with decoded per-state strobes.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       tck,
  input  logic       trst_,
  input  logic       tms,
  output tap_state_e state,
  output logic       test_logic_reset,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr
);

  tap_state_e state_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge tck or posedge trst_) begin
    if (trst_) state <= TLR;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      TLR:     state_nxt = tms ? TLR     : RTI;
      RTI:     state_nxt = tms ? SELDR   : RTI;
      SELDR:   state_nxt = tms ? SELIR   : CAPDR;
      CAPDR:   state_nxt = tms ? EXIT1DR : SHIFTDR;
      SHIFTDR: state_nxt = tms ? EXIT1DR : SHIFTDR;
      EXIT1DR: state_nxt = tms ? UPDDR   : PAUSEDR;
      PAUSEDR: state_nxt = tms ? EXIT2DR : PAUSEDR;
      EXIT2DR: state_nxt = tms ? UPDDR   : SHIFTDR;
      UPDDR:   state_nxt = tms ? SELDR   : RTI;
      SELIR:   state_nxt = tms ? TLR     : CAPIR;
      CAPIR:   state_nxt = tms ? EXIT1IR : SHIFTIR;
      SHIFTIR: state_nxt = tms ? EXIT1IR : SHIFTIR;
      EXIT1IR: state_nxt = tms ? UPDIR   : PAUSEIR;
      PAUSEIR: state_nxt = tms ? EXIT2IR : PAUSEIR;
      EXIT2IR: state_nxt = tms ? UPDIR   : SHIFTIR;
      UPDIR:   state_nxt = tms ? SELDR   : RTI;
      default: state_nxt = TLR;
    endcase
  end

  always_comb begin
    test_logic_reset = (state == TLR);
    capture_ir       = (state == CAPIR);
    shift_ir         = (state == SHIFTIR);
    update_ir        = (state == UPDIR);
    capture_dr       = (state == CAPDR);
    shift_dr         = (state == SHIFTDR);
    update_dr        = (state == UPDDR);
  end

endmodule

// File: rtl/jtag_gpio_tap.sv
// Device-side JTAG TAP for jtag_gpios: IR, IDCODE/BYPASS/GPIO data
// registers, GPIO update register and the negedge TDO stage.
module jtag_gpio_tap
  import jtag_tap_pkg::*;
#(
  parameter logic [31:0]          IDCODE_VAL = 32'h149511C3,
  parameter int                   NR_GPIO    = 4,
  parameter logic [IR_LENGTH-1:0] IR_CAPTURE = 4'b0101
) (
  input  logic               tck,
  input  logic               trst_,
  input  logic               tms,
  input  logic               tdi,
  output logic               tdo,
  output logic               tdo_oe,
  input  logic [NR_GPIO-1:0] gpio_in,
  output logic [NR_GPIO-1:0] gpio_out,
  output logic               gpio_upd,
  output logic [3:0]         tap_state
);

  // One physical DR shifter serves every data register; its active length
  // is chosen by where tdi is inserted.
  localparam int DR_W = (NR_GPIO > 32) ? NR_GPIO : 32;

  tap_state_e state;
  logic       test_logic_reset;
  logic       capture_ir, shift_ir, update_ir;
  logic       capture_dr, shift_dr, update_dr;

  logic [IR_LENGTH-1:0] ir;
  logic [IR_LENGTH-1:0] ir_shift;
  logic [IR_LENGTH-1:0] ir_shift_nxt;
  logic [DR_W-1:0]      dr_shift;
  logic [DR_W-1:0]      dr_shift_nxt;
  dr_sel_e              dr_sel;

  jtag_tap_fsm u_fsm (
    .tck              (tck),
    .trst_            (trst_),
    .tms              (tms),
    .state            (state),
    .test_logic_reset (test_logic_reset),
    .capture_ir       (capture_ir),
    .shift_ir         (shift_ir),
    .update_ir        (update_ir),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr)
  );

  assign tap_state = state;
  assign dr_sel    = decode_ir(ir);

  always_comb begin
    ir_shift_nxt = ir_shift;
    if (capture_ir)    ir_shift_nxt = IR_CAPTURE;
    else if (shift_ir) ir_shift_nxt = {tdi, ir_shift[IR_LENGTH-1:1]};
  end

  always_comb begin
    dr_shift_nxt = dr_shift;
    if (capture_dr) begin
      case (dr_sel)
        DR_IDCODE: dr_shift_nxt = DR_W'(IDCODE_VAL);
        DR_GPIO:   dr_shift_nxt = DR_W'(gpio_in);
        default:   dr_shift_nxt = '0;
      endcase
    end else if (shift_dr) begin
      dr_shift_nxt = dr_shift >> 1;
      case (dr_sel)
        DR_IDCODE: dr_shift_nxt[31]        = tdi;
        DR_GPIO:   dr_shift_nxt[NR_GPIO-1] = tdi;
        default:   dr_shift_nxt[0]         = tdi;
      endcase
    end
  end

  // TLR reloads IDCODE every cycle it is held, but gpio_out survives it:
  // only trst_ is allowed to drop the LEDs.
  always_ff @(posedge tck or posedge trst_) begin
    if (trst_) begin
      ir       <= IR_IDCODE;
      ir_shift <= '0;
      dr_shift <= '0;
      gpio_out <= '0;
      gpio_upd <= 1'b0;
    end else begin
      ir_shift <= ir_shift_nxt;
      dr_shift <= dr_shift_nxt;
      if (test_logic_reset) ir <= IR_IDCODE;
      else if (update_ir)   ir <= ir_shift;
      gpio_upd <= update_dr && (dr_sel == DR_GPIO);
      if (update_dr && (dr_sel == DR_GPIO)) gpio_out <= dr_shift[NR_GPIO-1:0];
    end
  end

  // Launching on the falling edge gives the host half a tck of setup.
  always_ff @(negedge tck or posedge trst_) begin
    if (trst_) begin
      tdo    <= 1'b0;
      tdo_oe <= 1'b0;
    end else begin
      tdo_oe <= shift_ir | shift_dr;
      if (shift_ir)      tdo <= ir_shift[0];
      else if (shift_dr) tdo <= dr_shift[0];
      else               tdo <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_gpio_tap.sv
// Directed bench for jtag_gpio_tap: IDCODE, IR capture, BYPASS, GPIO,
// synchronous TLR and asynchronous trst_ scenarios.
module tb_jtag_gpio_tap;

  localparam logic [31:0] IDCODE_EXP = 32'h149511C3;

  localparam logic [3:0] S_TLR     = 4'd0;
  localparam logic [3:0] S_RTI     = 4'd1;
  localparam logic [3:0] S_SELDR   = 4'd2;
  localparam logic [3:0] S_CAPDR   = 4'd3;
  localparam logic [3:0] S_SHIFTDR = 4'd4;
  localparam logic [3:0] S_EXIT1DR = 4'd5;
  localparam logic [3:0] S_UPDDR   = 4'd8;
  localparam logic [3:0] S_UPDIR   = 4'd15;

  logic       tck   = 1'b0;
  logic       trst_ = 1'b1;
  logic       tms   = 1'b0;
  logic       tdi   = 1'b0;
  logic [3:0] gpio_in = 4'b0000;
  logic       tdo;
  logic       tdo_oe;
  logic [3:0] gpio_out;
  logic       gpio_upd;
  logic [3:0] tap_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic s_tdo;
  logic s_oe;

  jtag_gpio_tap #(
    .IDCODE_VAL (32'h149511C3),
    .NR_GPIO    (4),
    .IR_CAPTURE (4'b0101)
  ) dut (
    .tck       (tck),
    .trst_     (trst_),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .tdo_oe    (tdo_oe),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .gpio_upd  (gpio_upd),
    .tap_state (tap_state)
  );

  always #5 tck = ~tck;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Called just after a negedge: sample what goes out on the coming posedge,
  // apply tms/tdi, then move past the next negedge.
  task automatic step(input logic m, input logic d);
    s_tdo = tdo;
    s_oe  = tdo_oe;
    tms   = m;
    tdi   = d;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  // From RTI into SHIFTDR, shift len bits, leave parked in EXIT1DR.
  task automatic scan_dr(input logic [31:0] data, input int len,
                         output logic [31:0] out, output int oe_cnt);
    out    = '0;
    oe_cnt = 0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < len; i++) begin
      step(i == len - 1, data[i]);
      out[i] = s_tdo;
      oe_cnt += int'(s_oe);
    end
  endtask

  // From RTI into SHIFTIR, shift 4 bits, leave parked in EXIT1IR.
  task automatic scan_ir(input logic [3:0] data, output logic [3:0] out, output int oe_cnt);
    out    = '0;
    oe_cnt = 0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, data[i]);
      out[i] = s_tdo;
      oe_cnt += int'(s_oe);
    end
  endtask

  // EXIT1x -> UPDx -> RTI
  task automatic finish_scan();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  logic [31:0] dr_out;
  logic [3:0]  ir_out;
  int          oe_cnt;
  logic        u0, u1, u2;

  initial begin
    // Reset state
    @(negedge tck);
    #1;
    check("rst_state", 32'(tap_state), 32'(S_TLR));
    check("rst_tdo", 32'(tdo), 32'd0);
    check("rst_tdo_oe", 32'(tdo_oe), 32'd0);
    check("rst_gpio_out", 32'(gpio_out), 32'd0);
    check("rst_gpio_upd", 32'(gpio_upd), 32'd0);
    trst_ = 1'b0;

    // IDCODE readout
    step(1'b0, 1'b0);
    check("rti_state", 32'(tap_state), 32'(S_RTI));
    scan_dr(32'h0, 32, dr_out, oe_cnt);
    check("idcode_val", dr_out, IDCODE_EXP);
    check("idcode_oe_cnt", 32'(oe_cnt), 32'd32);
    check("idcode_exit_state", 32'(tap_state), 32'(S_EXIT1DR));
    check("idcode_exit_oe", 32'(tdo_oe), 32'd0);
    check("idcode_exit_tdo", 32'(tdo), 32'd0);
    finish_scan();

    // IR capture pattern, then load BYPASS
    scan_ir(4'hF, ir_out, oe_cnt);
    check("ir_capture", 32'(ir_out), 32'h5);
    check("ir_oe_cnt", 32'(oe_cnt), 32'd4);
    step(1'b1, 1'b0);
    check("ir_upd_state", 32'(tap_state), 32'(S_UPDIR));
    step(1'b0, 1'b0);
    check("ir_rti_state", 32'(tap_state), 32'(S_RTI));

    // BYPASS: 8'hC1 plus one trailing 0, delayed by one bit
    scan_dr(32'h0C1, 9, dr_out, oe_cnt);
    check("bypass_seq", dr_out, 32'h182);
    check("bypass_oe_cnt", 32'(oe_cnt), 32'd9);
    finish_scan();

    // GPIO
    scan_ir(4'hA, ir_out, oe_cnt);
    finish_scan();
    gpio_in = 4'b1001;
    scan_dr(32'h6, 4, dr_out, oe_cnt);
    check("gpio_capture", dr_out, 32'h9);
    check("gpio_oe_cnt", 32'(oe_cnt), 32'd4);
    step(1'b1, 1'b0);
    check("gpio_upd_state", 32'(tap_state), 32'(S_UPDDR));
    u0 = gpio_upd;
    step(1'b0, 1'b0);
    u1 = gpio_upd;
    check("gpio_out_val", 32'(gpio_out), 32'h6);
    step(1'b0, 1'b0);
    u2 = gpio_upd;
    check("gpio_upd_pulse", 32'({u0, u1, u2}), 32'b010);

    // Synchronous reset by five tms=1 from SHIFTDR (IR=BYPASS)
    scan_ir(4'hF, ir_out, oe_cnt);
    finish_scan();
    step(1'b1, 1'b0);
    check("sr_seldr", 32'(tap_state), 32'(S_SELDR));
    step(1'b0, 1'b0);
    check("sr_capdr", 32'(tap_state), 32'(S_CAPDR));
    step(1'b0, 1'b0);
    check("sr_shiftdr", 32'(tap_state), 32'(S_SHIFTDR));
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("sr_state", 32'(tap_state), 32'(S_TLR));
    check("sr_gpio_out", 32'(gpio_out), 32'h6);
    check("sr_tdo_oe", 32'(tdo_oe), 32'd0);
    step(1'b0, 1'b0);
    scan_dr(32'h0, 32, dr_out, oe_cnt);
    check("sr_idcode", dr_out, IDCODE_EXP);
    finish_scan();
    // Unused opcode acts as BYPASS
    scan_ir(4'h3, ir_out, oe_cnt);
    finish_scan();
    scan_dr(32'hB, 4, dr_out, oe_cnt);
    check("op3_bypass", dr_out, 32'h6);
    finish_scan();
    check("op3_gpio_out", 32'(gpio_out), 32'h6);

    // Asynchronous reset mid-GPIO shift
    scan_ir(4'hA, ir_out, oe_cnt);
    finish_scan();
    gpio_in = 4'b1111;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("ar_pre_tdo", 32'(tdo), 32'd1);
    check("ar_pre_oe", 32'(tdo_oe), 32'd1);
    #1;
    trst_ = 1'b1;
    #1;
    check("ar_state", 32'(tap_state), 32'(S_TLR));
    check("ar_tdo", 32'(tdo), 32'd0);
    check("ar_tdo_oe", 32'(tdo_oe), 32'd0);
    check("ar_gpio_out", 32'(gpio_out), 32'd0);
    @(negedge tck);
    #1;
    trst_ = 1'b0;
    step(1'b0, 1'b0);
    scan_dr(32'h0, 32, dr_out, oe_cnt);
    check("ar_idcode", dr_out, IDCODE_EXP);
    finish_scan();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
